// File: rtl/core_bus_responder.sv
// rtl/core_bus_responder.sv - core bus target: byte RAM, TX FIFO, RX holding register, tick counter
module core_bus_responder #(
  parameter int          RAM_AW   = 12,
  parameter logic [19:0] IO_BASE  = 20'hFFF00,
  parameter int          FIFO_AW  = 4,
  parameter int          TICK_DIV = 25000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_wren,
  output logic [7:0]  cpu_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam int               PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);

  // storage without reset: RAM and FIFO slots keep their contents across reset
  logic [7:0] ram  [0:(1 << RAM_AW) - 1];
  logic [7:0] fifo [0:DEPTH - 1];

  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               tx_overflow, rx_avail, rx_overrun;
  logic [7:0]         rx_byte;
  logic [PW-1:0]      presc;
  logic [15:0]        tick;
  logic [7:0]         shadow;
  logic               rx_match_q, tlo_match_q;

  logic               ram_hit, io_hit;
  logic [3:0]         offset;
  logic [RAM_AW-1:0]  ram_idx;
  logic               sel_tx, sel_st, sel_rx, sel_tlo;
  logic               tx_push, tx_wr, tx_pop, tx_full, tx_empty, st_wr;
  logic               rx_pop, tlo_latch;
  logic [7:0]         rd_data;

  assign ram_hit  = (cpu_address >> RAM_AW) == 20'd0;
  assign io_hit   = cpu_address[19:4] == IO_BASE[19:4];
  assign offset   = cpu_address[3:0];
  assign ram_idx  = cpu_address[RAM_AW-1:0];

  assign sel_tx   = io_hit && (offset == 4'd0);
  assign sel_st   = io_hit && (offset == 4'd1);
  assign sel_rx   = io_hit && (offset == 4'd2);
  assign sel_tlo  = io_hit && (offset == 4'd3);

  assign tx_full  = count == DEPTH_C;
  assign tx_empty = count == '0;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : fifo[rptr];

  // a push against a full FIFO is judged on the pre-edge count, so a same-edge pop does not save it
  assign tx_push  = sel_tx && cpu_wren;
  assign tx_wr    = tx_push && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign st_wr    = sel_st && cpu_wren;

  // read side effects fire only on the first cycle the address lands on the register
  assign rx_pop    = sel_rx && !cpu_wren && !rx_match_q;
  assign tlo_latch = sel_tlo && !cpu_wren && !tlo_match_q;

  // read data mux; I/O registers return pre-edge state
  always_comb begin
    rd_data = 8'hFF;
    if (ram_hit) begin
      rd_data = ram[ram_idx];
    end else if (io_hit) begin
      case (offset)
        4'd1:    rd_data = {3'b000, rx_overrun, rx_avail, tx_overflow, tx_empty, tx_full};
        4'd2:    rd_data = rx_byte;
        4'd3:    rd_data = tick[7:0];
        4'd4:    rd_data = shadow;
        default: rd_data = 8'h00;
      endcase
    end
  end

  // RAM write port; a same-edge read sees the old byte
  always_ff @(posedge clock) begin
    if (cpu_wren && ram_hit) ram[ram_idx] <= cpu_out;
  end

  // FIFO slot write
  always_ff @(posedge clock) begin
    if (tx_wr) fifo[wptr] <= cpu_out;
  end

  // registered read data, updated on every edge including writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cpu_data <= 8'h00;
    else       cpu_data <= rd_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (tx_wr)  wptr <= wptr + FIFO_AW'(1);
      if (tx_pop) rptr <= rptr + FIFO_AW'(1);
      case ({tx_wr, tx_pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // status flags and RX holding register; new events win over a same-edge STATUS clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_overflow <= 1'b0;
      rx_avail    <= 1'b0;
      rx_overrun  <= 1'b0;
      rx_byte     <= 8'h00;
    end else begin
      if (st_wr) begin
        tx_overflow <= 1'b0;
        rx_overrun  <= 1'b0;
      end
      if (tx_push && tx_full) tx_overflow <= 1'b1;
      if (rx_valid) begin
        rx_byte  <= rx_data;
        rx_avail <= 1'b1;
        if (rx_avail && !rx_pop) rx_overrun <= 1'b1;
      end else if (rx_pop) begin
        rx_avail <= 1'b0;
      end
    end
  end

  // prescaler and free-running tick, plus the TICK_HI shadow captured on a TICK_LO read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      tick   <= 16'h0000;
      shadow <= 8'h00;
    end else begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
        tick  <= tick + 16'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      if (tlo_latch) shadow <= tick[15:8];
    end
  end

  // previous-cycle address match for the side-effect registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_match_q  <= 1'b0;
      tlo_match_q <= 1'b0;
    end else begin
      rx_match_q  <= sel_rx;
      tlo_match_q <= sel_tlo;
    end
  end

endmodule

// File: tb/tb_core_bus_responder.sv
// tb/tb_core_bus_responder.sv - scoreboard bench for core_bus_responder
module tb_core_bus_responder;

  localparam int          TDIV = 2;
  localparam logic [19:0] IO   = 20'hFFF00;
  localparam logic [19:0] IDLE = 20'h80000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] cpu_address = IDLE;
  logic [7:0]  cpu_out = 8'h00;
  logic        cpu_wren = 1'b0;
  logic [7:0]  cpu_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  core_bus_responder #(.RAM_AW(12), .IO_BASE(IO), .FIFO_AW(4), .TICK_DIV(TDIV)) dut (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
    .cpu_wren(cpu_wren), .cpu_data(cpu_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  // scoreboards
  logic [7:0]  rd_exp [$];
  logic [19:0] rd_adr [$];
  logic [7:0]  tx_exp [$];
  logic        rd_chk = 1'b0;
  logic        drv_ready = 1'b0;

  // reference model
  logic [7:0] m_fifo [$];
  logic [7:0] m_mem [int];
  bit         m_ovf, m_avail, m_ovr;
  logic [7:0] m_rxb, m_shadow;
  int         m_cnt;
  bit         m_prev_rx, m_prev_tlo;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_tick();
    return 16'((m_cnt / TDIV) % 65536);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    tx_exp.delete();
    m_ovf = 0; m_avail = 0; m_ovr = 0;
    m_rxb = 8'h00; m_shadow = 8'h00;
    m_cnt = 0; m_prev_rx = 0; m_prev_tlo = 0;
  endtask

  // one bus cycle, entered and left at a falling edge; exp_ovr >= 0 forces a fixed expected byte
  task automatic bus(input logic [19:0] a, input logic w, input logic [7:0] d,
                     input logic rv, input logic [7:0] rd, input int exp_ovr);
    logic [7:0]  e;
    bit          known, ramh, ioh, full, pop, rxpop, tlat;
    logic [3:0]  off;
    logic [15:0] t;
    cpu_address = a; cpu_wren = w; cpu_out = d;
    tx_ready = drv_ready; rx_valid = rv; rx_data = rd;
    ramh = a < 20'h01000;
    ioh  = a[19:4] == IO[19:4];
    off  = a[3:0];
    t    = m_tick();
    known = 1; e = 8'hFF;
    if (ramh) begin
      if (m_mem.exists(int'(a))) e = m_mem[int'(a)];
      else known = 0;
    end else if (ioh) begin
      case (off)
        4'd1:    e = {3'b000, m_ovr, m_avail, m_ovf, m_fifo.size() == 0, m_fifo.size() == 16};
        4'd2:    e = m_rxb;
        4'd3:    e = t[7:0];
        4'd4:    e = m_shadow;
        default: e = 8'h00;
      endcase
    end
    if (exp_ovr >= 0) begin
      e = exp_ovr[7:0];
      known = 1;
    end
    rd_chk = known;
    if (known) begin
      rd_exp.push_back(e);
      rd_adr.push_back(a);
    end
    @(posedge clock);
    full  = m_fifo.size() == 16;
    pop   = (m_fifo.size() > 0) && drv_ready;
    rxpop = ioh && off == 4'd2 && !w && !m_prev_rx;
    tlat  = ioh && off == 4'd3 && !w && !m_prev_tlo;
    if (ramh && w) m_mem[int'(a)] = d;
    if (ioh && off == 4'd1 && w) begin m_ovf = 0; m_ovr = 0; end
    if (ioh && off == 4'd0 && w) begin
      if (full) m_ovf = 1;
      else begin m_fifo.push_back(d); tx_exp.push_back(d); end
    end
    if (pop) void'(m_fifo.pop_front());
    if (rv) begin
      if (m_avail && !rxpop) m_ovr = 1;
      m_rxb = rd; m_avail = 1;
    end else if (rxpop) m_avail = 0;
    if (tlat) m_shadow = t[15:8];
    m_prev_rx  = ioh && off == 4'd2;
    m_prev_tlo = ioh && off == 4'd3;
    m_cnt++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(IDLE, 1'b0, 8'h00, 1'b0, 8'h00, -1);
  endtask

  // asynchronous reset asserted between edges; entered and left at a falling edge
  task automatic do_reset();
    check("tx_valid_before_reset", tx_valid, 1'b1);
    cpu_address = IDLE; cpu_wren = 1'b0; rx_valid = 1'b0;
    drv_ready = 1'b0; tx_ready = 1'b0; rd_chk = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("tx_valid_async_reset", tx_valid, 1'b0);
    check("tx_data_async_reset", tx_data, 8'h00);
    check("cpu_data_async_reset", cpu_data, 8'h00);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // read-data monitor
  always begin
    @(posedge clock);
    #1;
    if (rd_chk && !reset) begin
      if (rd_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL cpu_data: no expectation queued, got %0h", cpu_data);
      end else begin
        check($sformatf("cpu_data@%05h", rd_adr.pop_front()), cpu_data, rd_exp.pop_front());
      end
    end
  end

  // TX stream monitor: valid level each cycle, data at every handshake
  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      check("tx_valid", tx_valid, tx_exp.size() != 0);
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_data: unexpected byte %0h", tx_data);
        end else begin
          check("tx_data", tx_data, tx_exp.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [19:0] ra;
  logic        rw;
  int          k;

  initial begin
    model_reset();
    #1;
    check("cpu_data_reset", cpu_data, 8'h00);
    check("tx_valid_reset", tx_valid, 1'b0);
    check("tx_data_reset", tx_data, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // tick counter: TICK_LO at tick 0x01FF, TICK_HI after the increment returns the latched high byte
    while (m_cnt < 1022) idle(1);
    bus(IO + 20'd3, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFF);
    while (m_cnt < 1026) idle(1);
    bus(IO + 20'd4, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01);
    idle(1);
    bus(IO + 20'd3, 1'b0, 8'h00, 1'b0, 8'h00, -1);

    // RAM and unmapped space
    bus(20'h00010, 1'b1, 8'h5A, 1'b0, 8'h00, -1);
    bus(20'h00011, 1'b1, 8'hA5, 1'b0, 8'h00, -1);
    bus(20'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 8'h5A);
    bus(20'h80000, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFF);

    // fill to overflow, drain, clear
    drv_ready = 1'b0;
    for (int i = 0; i < 17; i++) bus(IO, 1'b1, 8'(i), 1'b0, 8'h00, -1);
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h05);
    drv_ready = 1'b1;
    idle(16);
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h06);
    bus(IO + 20'd1, 1'b1, 8'h00, 1'b0, 8'h00, -1);
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h02);

    // steady occupancy of 3 with a push and a pop every edge
    drv_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus(IO, 1'b1, 8'(8'hC0 + i), 1'b0, 8'h00, -1);
    drv_ready = 1'b1;
    for (int i = 0; i < 20; i++) bus(IO, 1'b1, 8'($urandom), 1'b0, 8'h00, -1);
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    idle(4);

    // RX holding register with overrun and a held RXDATA read
    bus(IDLE, 1'b0, 8'h00, 1'b1, 8'h41, -1);
    bus(IDLE, 1'b0, 8'h00, 1'b1, 8'h42, -1);
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h1A);
    for (int i = 0; i < 3; i++) bus(IO + 20'd2, 1'b0, 8'h00, 1'b0, 8'h00, 8'h42);
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h12);
    bus(IO + 20'd1, 1'b1, 8'h00, 1'b0, 8'h00, -1);
    // pop and new byte on the same edge: old byte returned, no overrun, still available
    bus(IDLE, 1'b0, 8'h00, 1'b1, 8'h51, -1);
    bus(IO + 20'd2, 1'b0, 8'h00, 1'b1, 8'h52, 8'h51);
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h0A);
    bus(IO + 20'd2, 1'b0, 8'h00, 1'b0, 8'h00, 8'h52);

    // reset in the middle of a drain
    drv_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus(IO, 1'b1, 8'(8'h70 + i), 1'b0, 8'h00, -1);
    drv_ready = 1'b1;
    idle(1);
    do_reset();
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h02);
    bus(20'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 8'h5A);
    bus(20'h00011, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5);

    // randomized traffic against the model
    ra = IDLE;
    for (int i = 0; i < 500; i++) begin
      k = $urandom_range(0, 9);
      if (k < 3)       ra = 20'h00020 + 20'($urandom_range(0, 31));
      else if (k == 3) ra = 20'h00FFF;
      else if (k < 8)  ra = IO + 20'($urandom_range(0, 6));
      else if (k == 8) begin
        case ($urandom_range(0, 3))
          0:       ra = 20'h01000;
          1:       ra = 20'h80000;
          2:       ra = 20'hFFEFF;
          default: ra = 20'hFFF10;
        endcase
      end
      rw = ($urandom_range(0, 2) == 0);
      drv_ready = 1'($urandom_range(0, 1));
      bus(ra, rw, 8'($urandom), 1'($urandom_range(0, 4) == 0), 8'($urandom), -1);
    end

    drv_ready = 1'b1;
    idle(20);
    bus(IO + 20'd1, 1'b1, 8'h00, 1'b0, 8'h00, -1);
    bus(IO + 20'd1, 1'b0, 8'h00, 1'b0, 8'h00, -1);
    idle(2);
    check("tx_scoreboard_empty", 16'(tx_exp.size()), 16'd0);
    check("rd_scoreboard_empty", 16'(rd_exp.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
